// File: rtl/fn_batch_pkg.sv
// Shared sizing for the call batcher and the memory_compute block it feeds.
package fn_batch_pkg;

  localparam int NUM_FN_CALLS_DEF  = 4;
  localparam int FN_CALL_WIDTH_DEF = 8;
  localparam int FLUSH_TIMEOUT_DEF = 8;

  // memory_compute sees one valid bit per lane and the packed lanes
  localparam int MC_VALID_WIDTH = NUM_FN_CALLS_DEF;
  localparam int MC_DATA_WIDTH  = NUM_FN_CALLS_DEF * FN_CALL_WIDTH_DEF;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HELD = 1'b1
  } fill_state_e;

endpackage

// File: rtl/fn_batch_idle_timer.sv
// Idle-cycle counter for a partially filled batch; saturates at TIMEOUT.
module fn_batch_idle_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fn_call_batcher.sv
// Packs single calls into lane batches and hands them to memory_compute
// through a one-deep output register.
//
// state   | meaning
// ST_FILL | fill buffer open, accepting calls
// ST_HELD | fill buffer closed, waiting for the output register to free up
module fn_call_batcher
  import fn_batch_pkg::*;
#(
  parameter int NUM_FN_CALLS  = NUM_FN_CALLS_DEF,
  parameter int FN_CALL_WIDTH = FN_CALL_WIDTH_DEF,
  parameter int FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  call_in_valid,
  output logic                                  call_in_ready,
  input  logic [FN_CALL_WIDTH-1:0]              call_in,
  input  logic                                  flush,
  output logic [NUM_FN_CALLS-1:0]               data_in_valid,
  input  logic                                  data_in_ready,
  output logic [NUM_FN_CALLS*FN_CALL_WIDTH-1:0] data_in
);

  localparam int CW = $clog2(NUM_FN_CALLS + 1);

  fill_state_e                             state_q, state_d;
  logic                                    ready_en;
  logic [CW-1:0]                           fill_count, fill_count_nxt;
  logic [NUM_FN_CALLS*FN_CALL_WIDTH-1:0]   fill_buf, fill_buf_nxt;
  logic [NUM_FN_CALLS-1:0]                 fill_mask;
  logic                                    accept, fill_empty, out_free;
  logic                                    close_now, transfer, expired;

  // ready_en keeps call_in_ready low until the first edge after reset
  assign call_in_ready = ready_en && (state_q == ST_FILL);
  assign accept        = call_in_valid && call_in_ready;
  assign fill_empty    = (fill_count == '0);
  assign out_free      = (data_in_valid == '0) || data_in_ready;

  always_comb begin
    fill_count_nxt = fill_count + CW'(accept);
    fill_buf_nxt   = fill_buf;
    if (accept) begin
      fill_buf_nxt[int'(fill_count)*FN_CALL_WIDTH +: FN_CALL_WIDTH] = call_in;
    end
    for (int k = 0; k < NUM_FN_CALLS; k++) begin
      fill_mask[k] = (k < int'(fill_count_nxt));
    end
  end

  always_comb begin
    state_d   = state_q;
    close_now = 1'b0;
    transfer  = 1'b0;
    case (state_q)
      ST_FILL: begin
        close_now = (fill_count_nxt == CW'(NUM_FN_CALLS))
                 || (expired && !fill_empty)
                 || (flush && (fill_count_nxt != '0));
        transfer  = close_now && out_free;
        if (close_now && !out_free) state_d = ST_HELD;
      end
      ST_HELD: begin
        transfer = out_free;
        if (out_free) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_FILL;
      ready_en      <= 1'b0;
      fill_count    <= '0;
      fill_buf      <= '0;
      data_in_valid <= '0;
      data_in       <= '0;
    end else begin
      state_q  <= state_d;
      ready_en <= 1'b1;
      if (transfer) begin
        data_in       <= fill_buf_nxt;
        data_in_valid <= fill_mask;
        fill_buf      <= '0;
        fill_count    <= '0;
      end else begin
        if (data_in_ready) begin
          data_in       <= '0;
          data_in_valid <= '0;
        end
        fill_buf   <= fill_buf_nxt;
        fill_count <= fill_count_nxt;
      end
    end
  end

  fn_batch_idle_timer #(
    .TIMEOUT(FLUSH_TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept || fill_empty),
    .run    (state_q == ST_FILL),
    .expired(expired)
  );

endmodule

// File: tb/tb_fn_call_batcher.sv
// Directed bench for fn_call_batcher with hand-computed batch contents.
module tb_fn_call_batcher;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        call_in_valid = 1'b0;
  logic        call_in_ready;
  logic [7:0]  call_in = '0;
  logic        flush = 1'b0;
  logic [3:0]  data_in_valid;
  logic        data_in_ready = 1'b0;
  logic [31:0] data_in;

  int errors = 0;
  int checks = 0;

  fn_call_batcher dut (
    .clk          (clk),
    .rst          (rst),
    .call_in_valid(call_in_valid),
    .call_in_ready(call_in_ready),
    .call_in      (call_in),
    .flush        (flush),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .data_in      (data_in)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] v);
    call_in_valid = 1'b1;
    call_in       = v;
    tick();
  endtask

  initial begin
    // reset
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 64'(call_in_ready), 64'h0);
    chk("rst_mask",  64'(data_in_valid), 64'h0);
    chk("rst_data",  64'(data_in),       64'h0);
    tick();
    tick();
    rst = 1'b0;
    chk("ready_low_before_edge", 64'(call_in_ready), 64'h0);
    tick();
    chk("ready_after_rst", 64'(call_in_ready), 64'h1);

    // full batch
    data_in_ready = 1'b1;
    send(8'h12);
    send(8'h23);
    send(8'h34);
    send(8'h45);
    call_in_valid = 1'b0;
    chk("full_mask", 64'(data_in_valid), 64'hf);
    chk("full_data", 64'(data_in),       64'h45342312);
    tick();
    chk("full_cleared", 64'(data_in_valid), 64'h0);

    // timeout: idle counter reaches 8 eight edges after the last accept
    send(8'h56);
    send(8'h67);
    call_in_valid = 1'b0;
    repeat (8) tick();
    chk("timeout_not_yet", 64'(data_in_valid), 64'h0);
    tick();
    chk("timeout_mask", 64'(data_in_valid), 64'h3);
    chk("timeout_data", 64'(data_in),       64'h00006756);
    tick();

    // flush together with an accept
    flush = 1'b1;
    send(8'h9a);
    call_in_valid = 1'b0;
    flush         = 1'b0;
    chk("flush_mask", 64'(data_in_valid), 64'h1);
    chk("flush_data", 64'(data_in),       64'h0000009a);
    tick();
    chk("flush_cleared", 64'(data_in_valid), 64'h0);

    // flush with nothing buffered does nothing
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("empty_flush_mask",  64'(data_in_valid), 64'h0);
    chk("empty_flush_ready", 64'(call_in_ready), 64'h1);

    // backpressure
    data_in_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i));
    call_in_valid = 1'b0;
    chk("bp_ready_low", 64'(call_in_ready), 64'h0);
    chk("bp_mask",      64'(data_in_valid), 64'hf);
    chk("bp_data",      64'(data_in),       64'h04030201);
    tick();
    tick();
    chk("bp_stable_mask", 64'(data_in_valid), 64'hf);
    chk("bp_stable_data", 64'(data_in),       64'h04030201);
    chk("bp_still_held",  64'(call_in_ready), 64'h0);
    data_in_ready = 1'b1;
    tick();
    chk("bp_second_mask", 64'(data_in_valid), 64'hf);
    chk("bp_second_data", 64'(data_in),       64'h08070605);
    chk("bp_ready_back",  64'(call_in_ready), 64'h1);
    tick();
    chk("bp_drained", 64'(data_in_valid), 64'h0);

    // reset mid-fill
    send(8'ha1);
    send(8'ha2);
    call_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_mask",  64'(data_in_valid), 64'h0);
    chk("midrst_ready", 64'(call_in_ready), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_ready_back", 64'(call_in_ready), 64'h1);
    send(8'hb1);
    send(8'hb2);
    send(8'hb3);
    chk("midrst_no_stale", 64'(data_in_valid), 64'h0);
    send(8'hb4);
    call_in_valid = 1'b0;
    chk("midrst_mask_new", 64'(data_in_valid), 64'hf);
    chk("midrst_data_new", 64'(data_in),       64'hb4b3b2b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fn_call_batcher.md
FN_CALL_BATCHER -- requirements
Module: fn_call_batcher

Interface
REQ-001 SHALL have parameter NUM_FN_CALLS, default 4, number of parallel lanes per batch.
REQ-002 SHALL have parameter FN_CALL_WIDTH, default 8, width of one packed call (concatenated operands).
REQ-003 SHALL have parameter FLUSH_TIMEOUT, default 8, idle cycles (>=1) before a partial batch is closed.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port call_in_valid  input  1  upstream single call present.
REQ-007 SHALL have port call_in_ready  output  1  batcher accepts call this cycle.
REQ-008 SHALL have port call_in  input  FN_CALL_WIDTH  single call payload.
REQ-009 SHALL have port flush  input  1  request to close the current partial batch.
REQ-010 SHALL have port data_in_valid  output  NUM_FN_CALLS  per-lane valid mask, driving memory_compute.
REQ-011 SHALL have port data_in_ready  input  1  memory_compute accepts the batch.
REQ-012 SHALL have port data_in  output  NUM_FN_CALLS*FN_CALL_WIDTH  packed batch; lane k at bits [k*W+W-1 : k*W].

Function
REQ-013 SHALL accept a call on a rising edge where call_in_valid && call_in_ready, writing it to fill lane fill_count, then incrementing fill_count.
REQ-014 SHALL place the first call accepted in a batch in lane 0, subsequent calls in ascending lanes.
REQ-015 SHALL close the fill batch when fill_count reaches NUM_FN_CALLS, when idle_count reaches FLUSH_TIMEOUT with fill_count>0, or when flush is high with fill_count>0 (counting any call accepted that same cycle).
REQ-016 SHALL hold idle_count at 0 while fill_count==0, reset it to 0 on every accept, otherwise increment it each cycle.
REQ-017 SHALL hold a closed batch in a single output register; transfer from fill to output occurs on the closing edge if the output register is empty or data_in_ready is high that cycle, else the fill buffer holds closed.
REQ-018 SHALL deassert call_in_ready while the fill buffer holds a closed batch not yet transferred.
REQ-019 SHALL drive data_in_valid as the contiguous low mask of fill_count ones (e.g. 3 calls -> 4'b0111) and zeros in unused lanes of data_in.
REQ-020 SHALL keep data_in and data_in_valid stable while data_in_valid!=0 and data_in_ready is low.
REQ-021 SHALL clear the output register on a cycle where data_in_ready is high and no new batch transfers in.
REQ-022 SHALL give latency of one cycle: a batch closed at edge N appears on data_in after edge N when the output register was free.
REQ-023 SHALL ignore flush when fill_count==0 and no call is accepted that cycle.
REQ-024 SHALL never drop or duplicate a call; output order equals acceptance order.

Reset
REQ-025 SHALL, on rst high, immediately clear fill_count, idle_count, fill closed flag, data_in_valid to 0, data_in to 0, and call_in_ready to 0.
REQ-026 SHALL discard partial and held batches on rst mid-operation; call_in_ready rises the first cycle after rst deasserts.

Structure
REQ-027 SHALL take NUM_FN_CALLS, FN_CALL_WIDTH, FLUSH_TIMEOUT defaults from shared package fn_batch_pkg, alongside memory_compute widths.
REQ-028 SHALL implement the idle counter as sub-module fn_batch_idle_timer (inputs clear, run; output expired).

Verification
REQ-029 SHALL cover full batch: calls 12,23,34,45 back-to-back, data_in_ready=1 -> data_in=45342312 mask 1111 one cycle after 4th accept.
REQ-030 SHALL cover timeout: calls 56,67 then idle -> mask 0011, data_in=00006756 after 8 idle cycles.
REQ-031 SHALL cover flush with accept: call 9a accepted with flush=1 -> mask 0001, data_in=0000009a.
REQ-032 SHALL cover backpressure: data_in_ready=0, 8 calls offered -> second batch held, call_in_ready low, first batch stable; ready=1 -> batches emitted in order, no loss.
REQ-033 SHALL cover reset mid-fill: 2 calls accepted then rst pulse -> mask 0000; next 4 calls form clean batch in lanes 0..3.
